// File: rtl/morse_pkg.sv
// Shared definitions for the Morse transmitter: FSM states, element
// lengths in Morse units and a helper that turns a unit count into a
// down-counter load value.
package morse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MARK  = 2'd1,
      SPACE = 2'd2,
      CGAP  = 2'd3
   } morse_state_e;

   localparam int unsigned DOT_UNITS    = 1;
   localparam int unsigned DASH_UNITS   = 3;
   localparam int unsigned ESPACE_UNITS = 1;
   localparam int unsigned CGAP_UNITS   = 3;

   // Counter runs from load value down to zero, so k units need k*U-1.
   function automatic int unsigned load_value(input int unsigned units,
                                              input int unsigned unit_cycles);
      return units * unit_cycles - 1;
   endfunction

endpackage

// File: rtl/morse_rom.sv
// Nibble to Morse code lookup. Pattern is left-justified, MSB first,
// 1 = dash, 0 = dot; len gives the number of valid elements (1..5).
module morse_rom
   import morse_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [2:0] len,
   output logic [4:0] pattern
);

   // Pure table lookup for the sixteen hex digits.
   always_comb begin
      len     = 3'd5;
      pattern = 5'b00000;
      case (nibble)
         4'h0: begin len = 3'd5; pattern = 5'b11111; end
         4'h1: begin len = 3'd5; pattern = 5'b01111; end
         4'h2: begin len = 3'd5; pattern = 5'b00111; end
         4'h3: begin len = 3'd5; pattern = 5'b00011; end
         4'h4: begin len = 3'd5; pattern = 5'b00001; end
         4'h5: begin len = 3'd5; pattern = 5'b00000; end
         4'h6: begin len = 3'd5; pattern = 5'b10000; end
         4'h7: begin len = 3'd5; pattern = 5'b11000; end
         4'h8: begin len = 3'd5; pattern = 5'b11100; end
         4'h9: begin len = 3'd5; pattern = 5'b11110; end
         4'hA: begin len = 3'd2; pattern = 5'b01000; end
         4'hB: begin len = 3'd4; pattern = 5'b10000; end
         4'hC: begin len = 3'd4; pattern = 5'b10100; end
         4'hD: begin len = 3'd3; pattern = 5'b10000; end
         4'hE: begin len = 3'd1; pattern = 5'b00000; end
         4'hF: begin len = 3'd4; pattern = 5'b00100; end
         default: begin len = 3'd5; pattern = 5'b00000; end
      endcase
   end

endmodule

// File: rtl/morse_tx.sv
// Morse-code transmitter: sends a hex digit (or, with MORSE_TX_BYTE_EN
// defined, both nibbles of a byte, high nibble first) as Morse timing on
// 'line', with a start/busy/done handshake. UNIT_CYCLES sets the length
// of one Morse unit in clock cycles.
module morse_tx
   import morse_pkg::*;
#(
   parameter int unsigned UNIT_CYCLES = 12500000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [7:0] data,
   output logic       line,
   output logic       busy,
   output logic       done
);

   localparam int CNT_W = $clog2(3 * UNIT_CYCLES);

   localparam logic [CNT_W-1:0] DOT_LOAD    = CNT_W'(load_value(DOT_UNITS, UNIT_CYCLES));
   localparam logic [CNT_W-1:0] DASH_LOAD   = CNT_W'(load_value(DASH_UNITS, UNIT_CYCLES));
   localparam logic [CNT_W-1:0] ESPACE_LOAD = CNT_W'(load_value(ESPACE_UNITS, UNIT_CYCLES));
   localparam logic [CNT_W-1:0] CGAP_LOAD   = CNT_W'(load_value(CGAP_UNITS, UNIT_CYCLES));

   morse_state_e     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       len_q, len_d;
   logic [4:0]       pat_q, pat_d;
   logic             line_q, line_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [3:0]       rom_nibble;
   logic [2:0]       rom_len;
   logic [4:0]       rom_pattern;

`ifdef MORSE_TX_BYTE_EN
   logic [3:0]       low_q, low_d;
   logic             pend_q, pend_d;

   // While idle the ROM looks at the incoming high nibble; afterwards it
   // looks at the latched low nibble waiting to be sent.
   assign rom_nibble = (state_q == IDLE) ? data[7:4] : low_q;
`else
   logic             unused_data_hi;

   assign rom_nibble     = data[3:0];
   assign unused_data_hi = ^data[7:4];
`endif

   morse_rom u_rom (
      .nibble  (rom_nibble),
      .len     (rom_len),
      .pattern (rom_pattern)
   );

   // Next-state logic: walks the elements of the current code, loading the
   // duration counter at each transition and flagging completion.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      len_d   = len_q;
      pat_d   = pat_q;
      done_d  = 1'b0;
`ifdef MORSE_TX_BYTE_EN
      low_d   = low_q;
      pend_d  = pend_q;
`endif

      case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (start) begin
               pat_d   = rom_pattern;
               len_d   = rom_len;
               idx_d   = 3'd0;
               cnt_d   = rom_pattern[4] ? DASH_LOAD : DOT_LOAD;
               state_d = MARK;
`ifdef MORSE_TX_BYTE_EN
               low_d   = data[3:0];
               pend_d  = 1'b1;
`endif
            end
         end

         MARK: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else if (idx_q == len_q - 3'd1) begin
               cnt_d   = CGAP_LOAD;
               state_d = CGAP;
            end else begin
               idx_d   = idx_q + 3'd1;
               pat_d   = {pat_q[3:0], 1'b0};
               cnt_d   = ESPACE_LOAD;
               state_d = SPACE;
            end
         end

         SPACE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
            end else begin
               cnt_d   = pat_q[4] ? DASH_LOAD : DOT_LOAD;
               state_d = MARK;
            end
         end

         CGAP: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 1'b1;
`ifdef MORSE_TX_BYTE_EN
            end else if (pend_q) begin
               pat_d   = rom_pattern;
               len_d   = rom_len;
               idx_d   = 3'd0;
               cnt_d   = rom_pattern[4] ? DASH_LOAD : DOT_LOAD;
               pend_d  = 1'b0;
               state_d = MARK;
`endif
            end else begin
               cnt_d   = '0;
               idx_d   = 3'd0;
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end

         default: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
      endcase

      line_d = (state_d == MARK);
      busy_d = (state_d != IDLE);
   end

   // State, counter and registered outputs; reset clears everything at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         idx_q   <= 3'd0;
         len_q   <= 3'd0;
         pat_q   <= 5'b00000;
         line_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         pat_q   <= pat_d;
         line_q  <= line_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

`ifdef MORSE_TX_BYTE_EN
   // Holds the low nibble until the high nibble and its gap have been sent.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         low_q  <= 4'h0;
         pend_q <= 1'b0;
      end else begin
         low_q  <= low_d;
         pend_q <= pend_d;
      end
   end
`endif

   assign line = line_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_morse_tx.sv
// Directed testbench for morse_tx with UNIT_CYCLES = 4. Expected waveforms
// are built from hand-written dot/dash strings.
module tb_morse_tx;

   localparam int UNIT = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] data;
   logic       line;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   bit    expWave[$];
   string codes[16] = '{"-----", ".----", "..---", "...--", "....-",
                        ".....", "-....", "--...", "---..", "----.",
                        ".-", "-...", "-.-.", "-..", ".", "..-."};

   morse_tx #(.UNIT_CYCLES(UNIT)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .data  (data),
      .line  (line),
      .busy  (busy),
      .done  (done)
   );

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   // Single comparison point: counts and reports every check.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Expected code string for a data byte; a space marks a character gap.
   function automatic string codeFor(input logic [7:0] d);
`ifdef MORSE_TX_BYTE_EN
      return {codes[d[7:4]], " ", codes[d[3:0]]};
`else
      return codes[d[3:0]];
`endif
   endfunction

   // Expand a dot/dash string into one expected 'line' bit per cycle.
   task automatic buildWave(input string code);
      expWave.delete();
      for (int i = 0; i < code.len(); i++) begin
         if (code[i] == " ") continue;
         repeat ((code[i] == "-") ? 3 * UNIT : UNIT) expWave.push_back(1'b1);
         if (i + 1 < code.len() && code[i + 1] != " ")
            repeat (UNIT) expWave.push_back(1'b0);
         else
            repeat (3 * UNIT) expWave.push_back(1'b0);
      end
   endtask

   // Starts a transmission at the current negedge and checks every cycle up
   // to and including the done cycle. interfereAt raises start mid-run;
   // resetAt aborts the run with an asynchronous reset.
   task automatic applyStimulus(input logic [7:0] d, input string name,
                                input int interfereAt, input int resetAt);
      buildWave(codeFor(d));
      start = 1'b1;
      data  = d;
      @(negedge clk);
      start = 1'b0;
      data  = d ^ 8'hA5;
      for (int c = 1; c <= expWave.size(); c++) begin
         checkOutput($sformatf("%s c%0d", name, c), {29'd0, line, busy, done},
                     {29'd0, expWave[c - 1], 1'b1, 1'b0});
         if (c == resetAt) begin
            reset = 1'b1;
            #1;
            checkOutput({name, " async clear"}, {29'd0, line, busy, done}, 32'd0);
            @(negedge clk);
            reset = 1'b0;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               checkOutput($sformatf("%s quiet%0d", name, k), {29'd0, line, busy, done}, 32'd0);
            end
            return;
         end
         if (c == interfereAt) begin
            start = 1'b1;
            data  = 8'h0A;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      checkOutput({name, " done"}, {29'd0, line, busy, done}, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      start = 1'b0;
      data  = 8'h00;
      repeat (2) @(negedge clk);
      checkOutput("reset state", {29'd0, line, busy, done}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      checkOutput("idle", {29'd0, line, busy, done}, 32'd0);

      $display("[TB] single dot, then back-to-back zero");
      applyStimulus(8'h0E, "e", 0, 0);
      applyStimulus(8'h00, "zero", 0, 0);
      @(negedge clk);
      checkOutput("idle after zero", {29'd0, line, busy, done}, 32'd0);

      applyStimulus(8'h05, "five", 0, 0);
      @(negedge clk);

      $display("[TB] start while busy");
      applyStimulus(8'h00, "busy start", 30, 0);
      @(negedge clk);
      checkOutput("no requeue", {29'd0, line, busy, done}, 32'd0);

      $display("[TB] reset mid-transmission");
      applyStimulus(8'h07, "reset", 0, 20);
      applyStimulus(8'h0E, "e after reset", 0, 0);
      @(negedge clk);

`ifdef MORSE_TX_BYTE_EN
      $display("[TB] byte mode");
      applyStimulus(8'h1E, "byte 1E", 0, 0);
      @(negedge clk);
`endif

      $display("[TB] full code table");
      for (int n = 0; n < 16; n++) begin
         applyStimulus({4'h9, 4'(n)}, $sformatf("nib%0h", n), 0, 0);
      end
      @(negedge clk);
      checkOutput("final idle", {29'd0, line, busy, done}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
